// File: rtl/apb_master.sv
// APB3 initiator: turns a single-entry command/response handshake into
// IDLE -> SETUP -> ACCESS bus transfers, with wait-state handling and a stall timeout.
module apb_master #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PWRITE,
    output logic [DATAWIDTH-1:0] PWDATA,
    input  logic [DATAWIDTH-1:0] PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Counter only ever needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t                 state_q, state_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
    logic [DATAWIDTH-1:0]   pwdata_q, pwdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    // Reads leave the last write data on the bus to avoid toggling.
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                    end
                    psel_d  = 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                psel_d     = 1'b1;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
                state_d    = ACCESS;
            end

            ACCESS: begin
                // PREADY is checked first so a same-cycle completion beats the timeout.
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    state_d     = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master against a small RAM-backed APB slave with
// programmable wait states, error injection and a hang mode.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;

    apb_master #(.DATAWIDTH(32), .ADDRWIDTH(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // RAM slave: PREADY rises after slv_wait ACCESS cycles unless hung.
    logic [31:0] ram [0:255];
    logic [7:0]  wcnt;
    logic        slv_hang;
    logic        slv_err;
    int          slv_wait;

    always_comb begin
        PREADY  = PSEL && PENABLE && !slv_hang && (int'(wcnt) == slv_wait);
        PSLVERR = slv_err && PREADY;
        PRDATA  = ram[PADDR];
    end

    always @(posedge PCLK) begin
        if (PRESET) begin
            wcnt <= 8'd0;
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
        end else begin
            if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 8'd1;
            else wcnt <= 8'd0;
            if (PSEL && PENABLE && PREADY && PWRITE) ram[PADDR] <= PWDATA;
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Issues one command and collects bus/response observations (no judging here).
    task automatic run_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                            output int psel_c, output int pen_c, output int lat,
                            output logic [31:0] rd, output logic er, output logic stable,
                            output logic rdy_after, output logic pulse_after, output logic got);
        psel_c = 0; pen_c = 0; lat = 0; rd = '0; er = 1'b0;
        stable = 1'b1; rdy_after = 1'b0; got = 1'b0;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        for (int i = 1; i <= 60 && !got; i++) begin
            step();
            if (i == 1) begin
                cmd_valid = 1'b0;
                cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
            end
            if (PSEL) psel_c++;
            if (PENABLE) pen_c++;
            if (PSEL && PADDR !== a) stable = 1'b0;
            if (rsp_valid) begin
                got = 1'b1; lat = i; rd = rsp_rdata; er = rsp_err; rdy_after = cmd_ready;
            end
        end
        step();
        pulse_after = rsp_valid;
    endtask

    int          ps, pe, lt;
    logic [31:0] rdv;
    logic        erv, stb, rdy, pls, got;

    task automatic test_reset();
        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        slv_hang = 1'b0; slv_err = 1'b0; slv_wait = 0;
        #12;
        n_cmp++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 00000", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
        end
        n_cmp++;
        if ({PADDR, PWDATA, rsp_rdata} !== 72'd0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%h required all zero", PADDR, PWDATA, rsp_rdata);
        end
        step();
        PRESET = 1'b0;
        step();
        n_cmp++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
            n_bad++; $display("FAIL reset_release: cmd_ready=%b PSEL=%b required 1/0", cmd_ready, PSEL);
        end
    endtask

    task automatic test_write_zero_wait();
        slv_wait = 0;
        run_xfer(1'b1, 8'h10, 32'hDEADBEEF, ps, pe, lt, rdv, erv, stb, rdy, pls, got);
        n_cmp++;
        if (got !== 1'b1 || lt != 3) begin
            n_bad++; $display("FAIL wr0_latency: got=%b lat=%0d required 1/3", got, lt);
        end
        n_cmp++;
        if (ps != 2 || pe != 1) begin
            n_bad++; $display("FAIL wr0_phases: psel=%0d penable=%0d required 2/1", ps, pe);
        end
        n_cmp++;
        if (erv !== 1'b0 || rdv !== 32'd0) begin
            n_bad++; $display("FAIL wr0_rsp: err=%b rdata=%h required 0/00000000", erv, rdv);
        end
        n_cmp++;
        if (stb !== 1'b1 || pls !== 1'b0 || rdy !== 1'b1) begin
            n_bad++; $display("FAIL wr0_misc: stable=%b pulse_after=%b ready=%b required 1/0/1", stb, pls, rdy);
        end
        n_cmp++;
        if (ram[8'h10] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL wr0_ram: got %h required deadbeef", ram[8'h10]);
        end
        n_cmp++;
        if (PADDR !== 8'h10 || PWDATA !== 32'hDEADBEEF || PWRITE !== 1'b1) begin
            n_bad++; $display("FAIL wr0_bus_hold: %h/%h/%b required 10/deadbeef/1", PADDR, PWDATA, PWRITE);
        end
    endtask

    task automatic test_read_wait();
        slv_wait = 3;
        run_xfer(1'b0, 8'h10, 32'h0, ps, pe, lt, rdv, erv, stb, rdy, pls, got);
        n_cmp++;
        if (pe != 4 || ps != 5 || lt != 6) begin
            n_bad++; $display("FAIL rdw_timing: penable=%0d psel=%0d lat=%0d required 4/5/6", pe, ps, lt);
        end
        n_cmp++;
        if (rdv !== 32'hDEADBEEF || erv !== 1'b0) begin
            n_bad++; $display("FAIL rdw_rsp: rdata=%h err=%b required deadbeef/0", rdv, erv);
        end
        n_cmp++;
        if (stb !== 1'b1) begin
            n_bad++; $display("FAIL rdw_addr_stable: got %b required 1", stb);
        end
        n_cmp++;
        if (PWDATA !== 32'hDEADBEEF || PWRITE !== 1'b0) begin
            n_bad++; $display("FAIL rdw_pwdata_hold: %h/%b required deadbeef/0", PWDATA, PWRITE);
        end
        n_cmp++;
        if (rsp_rdata !== 32'hDEADBEEF || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rdw_rsp_hold: rdata=%h valid=%b required deadbeef/0", rsp_rdata, rsp_valid);
        end
    endtask

    task automatic test_slave_error();
        slv_wait = 0; slv_err = 1'b1;
        run_xfer(1'b0, 8'hFF, 32'h0, ps, pe, lt, rdv, erv, stb, rdy, pls, got);
        slv_err = 1'b0;
        n_cmp++;
        if (erv !== 1'b1 || rdv !== 32'd0 || lt != 3) begin
            n_bad++; $display("FAIL err_rsp: err=%b rdata=%h lat=%0d required 1/00000000/3", erv, rdv, lt);
        end
        n_cmp++;
        if (rsp_err !== 1'b1) begin
            n_bad++; $display("FAIL err_hold: got %b required 1", rsp_err);
        end
        run_xfer(1'b0, 8'h10, 32'h0, ps, pe, lt, rdv, erv, stb, rdy, pls, got);
        n_cmp++;
        if (erv !== 1'b0 || rdv !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL err_next: err=%b rdata=%h required 0/deadbeef", erv, rdv);
        end
    endtask

    task automatic test_timeout();
        slv_hang = 1'b1;
        run_xfer(1'b0, 8'h20, 32'h0, ps, pe, lt, rdv, erv, stb, rdy, pls, got);
        slv_hang = 1'b0;
        n_cmp++;
        if (got !== 1'b1 || pe != 16 || ps != 17 || lt != 18) begin
            n_bad++; $display("FAIL to_timing: got=%b penable=%0d psel=%0d lat=%0d required 1/16/17/18", got, pe, ps, lt);
        end
        n_cmp++;
        if (erv !== 1'b1 || rdv !== 32'd0) begin
            n_bad++; $display("FAIL to_rsp: err=%b rdata=%h required 1/00000000", erv, rdv);
        end
        n_cmp++;
        if (rdy !== 1'b1 || pls !== 1'b0) begin
            n_bad++; $display("FAIL to_ready: ready=%b pulse_after=%b required 1/0", rdy, pls);
        end
        // Slave answers in the very cycle the timeout would fire.
        slv_wait = 15;
        run_xfer(1'b0, 8'h10, 32'h0, ps, pe, lt, rdv, erv, stb, rdy, pls, got);
        slv_wait = 0;
        n_cmp++;
        if (pe != 16 || lt != 18 || erv !== 1'b0 || rdv !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL to_pready_wins: penable=%0d lat=%0d err=%b rdata=%h required 16/18/0/deadbeef", pe, lt, erv, rdv);
        end
    endtask

    task automatic test_back_to_back();
        int acc [2];
        int rcy [2];
        int k, nr;
        logic [31:0] last_rd;
        logic busy_accept, acc_now;
        k = 0; nr = 0; last_rd = '0; busy_accept = 1'b0;
        acc[0] = 0; acc[1] = 0; rcy[0] = 0; rcy[1] = 0;
        slv_wait = 0;
        cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 32'h11; cmd_valid = 1'b1;
        for (int i = 1; i <= 40 && nr < 2; i++) begin
            acc_now = cmd_ready && cmd_valid;
            if (acc_now && PSEL) busy_accept = 1'b1;
            step();
            if (acc_now) begin
                acc[k] = i; k++;
                if (k == 1) begin
                    cmd_write = 1'b0; cmd_addr = 8'h01; cmd_wdata = 32'h0;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                rcy[nr] = i; nr++; last_rd = rsp_rdata;
            end
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (k != 2 || acc[0] != 1 || acc[1] != 4 || busy_accept !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept: count=%0d at %0d,%0d busy=%b required 2 at 1,4 busy=0", k, acc[0], acc[1], busy_accept);
        end
        n_cmp++;
        if (nr != 2 || rcy[0] != 3 || rcy[1] != 6) begin
            n_bad++; $display("FAIL b2b_rsp_spacing: count=%0d at %0d,%0d required 2 at 3,6", nr, rcy[0], rcy[1]);
        end
        n_cmp++;
        if (last_rd !== 32'h11 || ram[8'h01] !== 32'h11) begin
            n_bad++; $display("FAIL b2b_data: rdata=%h ram=%h required 00000011/00000011", last_rd, ram[8'h01]);
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        pulses = 0;
        slv_hang = 1'b1;
        cmd_write = 1'b0; cmd_addr = 8'h30; cmd_wdata = 32'h0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        n_cmp++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_access: PSEL=%b PENABLE=%b required 1/1", PSEL, PENABLE);
        end
        #2;
        PRESET = 1'b1;
        #1;
        n_cmp++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: PSEL=%b PENABLE=%b rsp_valid=%b required 0/0/0", PSEL, PENABLE, rsp_valid);
        end
        n_cmp++;
        if (rsp_rdata !== 32'd0 || PADDR !== 8'd0) begin
            n_bad++; $display("FAIL rst_async_data: rdata=%h PADDR=%h required 00000000/00", rsp_rdata, PADDR);
        end
        slv_hang = 1'b0;
        step();
        step();
        PRESET = 1'b0;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL rst_ready: got %b required 1", cmd_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || PSEL !== 1'b0) begin
            n_bad++; $display("FAIL rst_no_rsp: pulses=%0d PSEL=%b required 0/0", pulses, PSEL);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that converts a single-entry command/response interface into APB3 transfers (IDLE -> SETUP -> ACCESS) toward APB slaves such as the team's RAM-backed APB slave.
- Handles wait states via PREADY and captures PSLVERR.
- Aborts a stalled transfer after a programmable timeout.
- Sits between the system-side controller/bench driver and the peripheral APB bus.

Parameters:
- DATAWIDTH, 32: width of PWDATA/PRDATA and of the command/response data.
- ADDRWIDTH, 8: width of PADDR and cmd_addr.
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRWIDTH  transfer address.
- cmd_wdata  in  DATAWIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and aborts.
- rsp_err  out  1  PSLVERR or timeout on the completed transfer.
- PSEL  out  1  slave select.
- PENABLE  out  1  access phase.
- PADDR  out  ADDRWIDTH  address.
- PWRITE  out  1  direction.
- PWDATA  out  DATAWIDTH  write data.
- PRDATA  in  DATAWIDTH  read data from the slave.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error; sampled only when PREADY=1 in ACCESS.

Behaviour:
- Reset (asynchronous on PRESET high):
  - State = IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err and the wait counter are all 0.
  - cmd_ready = 1 once PRESET deasserts.
- States: IDLE, SETUP, ACCESS. All outputs are registered except cmd_ready, which is combinational: (State == IDLE).
- IDLE:
  - PSEL=0, PENABLE=0.
  - On cmd_valid && cmd_ready: latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, set PSEL=1, go to SETUP.
  - PWDATA is loaded only for writes; for reads it holds its previous value.
- SETUP (exactly one cycle): PSEL=1, PENABLE=0. Next edge: PENABLE=1, wait counter cleared, go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA are held stable for the whole access, including wait states.
  - PREADY=1 completes the transfer. On that edge:
    - PSEL=0, PENABLE=0.
    - rsp_valid=1 for exactly one cycle.
    - rsp_err=PSLVERR.
    - rsp_rdata=PRDATA if read, else 0.
    - Go to IDLE.
  - PREADY=0 with TIMEOUT>0: counter increments each cycle. When the counter reaches TIMEOUT-1 and PREADY is still 0, abort:
    - PSEL=0, PENABLE=0.
    - rsp_valid=1, rsp_err=1, rsp_rdata=0.
    - Go to IDLE.
  - PREADY=0 with TIMEOUT=0: wait indefinitely.
  - If PREADY goes high in the same cycle the timeout would fire, PREADY wins (normal completion).
- Latency:
  - Zero-wait transfer: command accepted at edge N; rsp_valid high after edge N+2.
  - Minimum issue interval is 3 cycles, since cmd_ready returns in the cycle after completion. No back-to-back transfers without an IDLE cycle.
- Bus hold after completion: PADDR/PWRITE/PWDATA keep their last values in IDLE (no toggling).
- Response hold: rsp_rdata and rsp_err hold until the next completion. rsp_valid is 0 except for the completion pulse.
- Command handling:
  - cmd_valid while not in IDLE is ignored; cmd_ready=0, so there is no loss by handshake.
  - Command fields are sampled only at acceptance.
- Reset mid-transfer: bus returns to the reset state immediately (asynchronous) and no response is issued.
- Illegal state encoding: go to IDLE.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd write addr=0x10 data=0xDEADBEEF, PREADY=1.
  - Required: PSEL high 2 cycles, PENABLE high 1 cycle, PADDR=0x10, PWDATA=0xDEADBEEF; rsp_valid 1 cycle with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: cmd read addr=0x10, PREADY low 3 cycles, then high with PRDATA=0xDEADBEEF.
  - Required: PENABLE high 4 cycles with PADDR stable; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Slave error:
  - Stimulus: read addr=0xFF, PREADY=1 with PSLVERR=1.
  - Required: rsp_err=1; the next transfer reports rsp_err=0.
- Timeout (TIMEOUT=16):
  - Stimulus: PREADY held 0.
  - Required: abort after 16 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; PSEL=0; cmd_ready=1 next cycle.
- Back-to-back:
  - Stimulus: cmd_valid held high with 2 queued commands (write 0x01=0x11, then read 0x01), against the RAM APB slave model.
  - Required: second command accepted only in IDLE; read returns 0x11; transfer spacing is 3 cycles.
- Reset mid-access:
  - Stimulus: assert PRESET while in ACCESS.
  - Required: PSEL/PENABLE/rsp_valid go to 0 immediately; no response pulse; cmd_ready=1 after release.
